// File: rtl/sorted_drain.sv
// rtl/sorted_drain.sv - insertion-sorted burst buffer, filled by a writer and drained largest-first
// Entries stay in descending order; ties insert after existing equal values.
module sorted_drain #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic                  start,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [CW-1:0]         count,
   output logic                  draining
);

   localparam logic [0:0] FILL  = 1'b0;
   localparam logic [0:0] DRAIN = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] entry_q [DEPTH];
   logic [DATA_WIDTH-1:0] entry_d [DEPTH];
   logic [DATA_WIDTH-1:0] ins     [DEPTH];
   logic [DEPTH-1:0]      ge;
   logic                  accept;
   logic                  pop;

   assign din_ready  = (state_q == FILL) && (count_q < CW'(DEPTH));
   assign dout_valid = (state_q == DRAIN) && (count_q != '0);
   assign dout       = dout_valid ? entry_q[0] : '0;
   assign count      = count_q;
   assign draining   = (state_q == DRAIN);

   assign accept = din_valid && din_ready;
   assign pop    = dout_valid && dout_ready;

   // ge is a prefix mask over the occupied entries; din lands just past its last set bit.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ge[i] = (CW'(i) < count_q) && (entry_q[i] >= din);
      end
      ins[0] = ge[0] ? entry_q[0] : din;
      for (int i = 1; i < DEPTH; i++) begin
         ins[i] = ge[i] ? entry_q[i] : (ge[i-1] ? din : entry_q[i-1]);
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      entry_d = entry_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               entry_d = ins;
               count_d = count_q + 1'b1;
            end
            if (start && (accept || (count_q != '0))) begin
               state_d = DRAIN;
            end
         end
         default: begin
            if (pop) begin
               for (int i = 0; i < DEPTH - 1; i++) begin
                  entry_d[i] = entry_q[i+1];
               end
               entry_d[DEPTH-1] = '0;
               count_d = count_q - 1'b1;
               if (count_q == CW'(1)) begin
                  state_d = FILL;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         entry_q <= entry_d;
      end
   end

endmodule

// File: tb/tb_sorted_drain.sv
// tb/tb_sorted_drain.sv - directed vector bench for sorted_drain
module tb_sorted_drain;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       start;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ready;
   logic [3:0] count;
   logic       draining;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sorted_drain #(.DATA_WIDTH(8), .DEPTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .start      (start),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .count      (count),
      .draining   (draining)
   );

   // Expected outputs describe the state before the vector's clock edge.
   typedef struct {
      logic       rst;
      logic [7:0] din;
      logic       dv;
      logic       st;
      logic       dr;
      logic       e_rdy;
      logic       e_dv;
      logic [7:0] e_dout;
      logic [3:0] e_cnt;
      logic       e_drn;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [7:0] d, input logic dv, input logic st,
                      input logic dr, input logic e_rdy, input logic e_dv, input logic [7:0] e_dout,
                      input logic [3:0] e_cnt, input logic e_drn);
      vec_t v;
      v.rst = rst; v.din = d; v.dv = dv; v.st = st; v.dr = dr;
      v.e_rdy = e_rdy; v.e_dv = e_dv; v.e_dout = e_dout; v.e_cnt = e_cnt; v.e_drn = e_drn;
      vecs.push_back(v);
   endtask

   task automatic wr(input logic [7:0] d, input logic [3:0] c);
      add(0, d, 1, 0, 0, 1, 0, 8'd0, c, 0);
   endtask

   task automatic rd(input logic dr, input logic [7:0] e, input logic [3:0] c);
      add(0, 8'd0, 0, 0, dr, 0, 1, e, c, 1);
   endtask

   task automatic idle_fill(input logic [3:0] c);
      add(0, 8'd0, 0, 0, 0, c != 4'd8, 0, 8'd0, c, 0);
   endtask

   task automatic check(input string name, input int idx, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
      end
   endtask

   logic [7:0] h_in  [8] = '{8'd3, 8'd200, 8'd3, 8'd17, 8'd255, 8'd0, 8'd17, 8'd90};
   logic [7:0] h_exp [8] = '{8'd255, 8'd200, 8'd90, 8'd17, 8'd17, 8'd3, 8'd3, 8'd0};

   initial begin
      // basic sort
      idle_fill(0);
      wr(3, 0); wr(9, 1); wr(1, 2); wr(7, 3);
      add(0, 0, 0, 1, 0, 1, 0, 0, 4, 0);
      rd(1, 9, 4); rd(1, 7, 3); rd(1, 3, 2); rd(1, 1, 1);
      idle_fill(0);
      // duplicates and full
      wr(5, 0); wr(5, 1); wr(2, 2); wr(5, 3); wr(8, 4); wr(0, 5); wr(255, 6); wr(5, 7);
      add(0, 200, 1, 0, 0, 0, 0, 0, 8, 0);
      add(0, 0, 0, 1, 0, 0, 0, 0, 8, 0);
      rd(1, 255, 8); rd(1, 8, 7); rd(1, 5, 6); rd(1, 5, 5);
      rd(1, 5, 4); rd(1, 5, 3); rd(1, 2, 2); rd(1, 0, 1);
      idle_fill(0);
      // backpressure
      wr(4, 0); wr(6, 1);
      add(0, 0, 0, 1, 0, 1, 0, 0, 2, 0);
      rd(0, 6, 2); rd(0, 6, 2); rd(1, 6, 2); rd(0, 4, 1); rd(1, 4, 1);
      idle_fill(0);
      // start edge cases
      add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      idle_fill(0);
      add(0, 10, 1, 1, 0, 1, 0, 0, 0, 0);
      rd(0, 10, 1); rd(1, 10, 1);
      idle_fill(0);
      // reset mid-drain
      wr(1, 0); wr(2, 1); wr(3, 2);
      add(0, 0, 0, 1, 0, 1, 0, 0, 3, 0);
      rd(1, 3, 3);
      add(1, 0, 0, 0, 0, 0, 1, 2, 2, 1);
      idle_fill(0);
      wr(7, 0);
      add(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
      rd(1, 7, 1);
      idle_fill(0);
      // writes and start ignored while draining
      wr(20, 0); wr(10, 1);
      add(0, 0, 0, 1, 0, 1, 0, 0, 2, 0);
      add(0, 99, 1, 1, 0, 0, 1, 20, 2, 1);
      add(0, 99, 1, 0, 1, 0, 1, 20, 2, 1);
      add(0, 99, 1, 0, 1, 0, 1, 10, 1, 1);
      idle_fill(0);
      wr(50, 0);
      add(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
      rd(1, 50, 1);
      idle_fill(0);

      reset = 1; din = 0; din_valid = 0; start = 0; dout_ready = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;

      foreach (vecs[i]) begin
         reset = vecs[i].rst; din = vecs[i].din; din_valid = vecs[i].dv;
         start = vecs[i].st; dout_ready = vecs[i].dr;
         #1;
         check("din_ready",  i, din_ready,  vecs[i].e_rdy);
         check("dout_valid", i, dout_valid, vecs[i].e_dv);
         check("dout",       i, dout,       vecs[i].e_dout);
         check("count",      i, count,      vecs[i].e_cnt);
         check("draining",   i, draining,   vecs[i].e_drn);
         @(posedge clk); #1;
      end
      reset = 0; din_valid = 0; start = 0; dout_ready = 0;

      // full burst, then bounded drain compared against a hand-sorted list
      for (int k = 0; k < 8; k++) begin
         din = h_in[k]; din_valid = 1; start = (k == 7);
         @(posedge clk); #1;
      end
      din_valid = 0; start = 0; dout_ready = 1;
      for (int k = 0; k < 8; k++) begin
         int waited = 0;
         while (!dout_valid && waited < 20) begin
            @(posedge clk); #1; waited++;
         end
         check("burst_timeout", k, waited < 20, 1);
         check("burst_dout", k, dout, h_exp[k]);
         @(posedge clk); #1;
      end
      check("burst_end_valid", 0, dout_valid, 0);
      check("burst_end_ready", 0, din_ready, 1);
      dout_ready = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sorted_drain.md
Name: sorted_drain

Overview:
- Collects a burst of unsigned values, then returns them largest-first.
- Fill side: a valid/ready writer. Drain side: a valid/ready reader.
- Storage is a DEPTH-entry register array kept in descending order by insertion on every accepted write.
- Downstream stream-statistics blocks use it to replay ranked values (largest, second largest, ...) instead of tracking only one rank.

Parameters:
- DATA_WIDTH, 8, width of each unsigned data value.
- DEPTH, 8, maximum number of stored values (>= 2).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous reset, active-high.
- din  input  DATA_WIDTH  write data.
- din_valid  input  1  write request.
- din_ready  output  1  high when a write can be accepted.
- start  input  1  single-cycle request to switch from FILL to DRAIN.
- dout  output  DATA_WIDTH  current largest stored value; 0 when dout_valid is low.
- dout_valid  output  1  dout holds a value to be read.
- dout_ready  input  1  reader accepts dout.
- count  output  $clog2(DEPTH+1)  number of stored entries.
- draining  output  1  high in DRAIN state.

Behaviour:
- Reset (takes effect at the clock edge where reset=1; mid-operation included):
  - state=FILL, count=0, all entries=0.
  - din_ready=1, dout=0, dout_valid=0, draining=0.
  - Stored data is discarded, including data mid-drain.
- States: FILL, DRAIN.
- FILL:
  - din_ready = (count < DEPTH). dout_valid=0, dout=0.
  - Write accept condition: din_valid && din_ready.
  - On accept, din is inserted at the position keeping entry[0] >= entry[1] >= ... >= entry[count-1].
  - Ties: the new value goes after all existing equal values.
  - Duplicates are separate entries.
  - count increments. Result is visible the next cycle.
  - Write while full (count==DEPTH): not accepted, no state change, value dropped by the protocol (din_ready=0).
- FILL -> DRAIN:
  - Transition: start=1 and (count>0 or a write is accepted in the same cycle).
  - Same-cycle start + accepted write: the write is included, then the block enters DRAIN.
  - start with count==0 and no write: ignored, stays in FILL.
- DRAIN:
  - din_ready=0; din/din_valid ignored; start ignored.
  - dout_valid = (count>0). dout = entry[0].
  - On dout_valid && dout_ready: entries shift up one (entry[i] <= entry[i+1]), vacated tail entry <= 0, count decrements.
  - The next value is presented on the following cycle.
  - dout and dout_valid hold stable while dout_ready=0.
- DRAIN -> FILL: on the cycle the last entry is popped (count 1 -> 0). The next cycle is FILL with din_ready=1 and dout_valid=0.
- Latency:
  - start at cycle t -> dout_valid=1 at t+1.
  - Back-to-back reads with dout_ready held high deliver one value per cycle.
  - A burst of N values drains in N cycles.
- Comparison is unsigned over the full DATA_WIDTH. No arithmetic overflow is possible; count never exceeds DEPTH.
- Outputs are driven from registers (state, count, entry[0]). No combinational path from din to dout.

Test Plan:
- Basic sort: reset, write 3, 9, 1, 7, start, dout_ready=1 -> dout sequence 9, 7, 3, 1 on consecutive cycles. Then dout_valid=0, draining=0, din_ready=1.
- Duplicates and full: write 5, 5, 2, 5, 8, 0, 255, 5 (DEPTH=8).
  - din_ready=0 after the eighth write; a ninth write of 200 is not accepted.
  - Drain -> 255, 8, 5, 5, 5, 5, 2, 0.
- Backpressure: write 4, 6, start, then dout_ready pattern 0, 0, 1, 0, 1 -> dout holds 6 across the two stalled cycles, then 4 held across one stall, then dout_valid=0.
- Start edge cases:
  - start with count=0 and no write -> remains FILL, dout_valid=0.
  - start together with the first write of 10 -> next cycle draining=1, dout=10.
- Reset mid-drain: write 1, 2, 3, start, pop one (3), assert reset one cycle -> count=0, dout_valid=0, FILL. A subsequent write of 7 and start yields only 7.
- Ignore input in DRAIN: during drain of 20, 10 drive din_valid=1 with din=99 -> outputs 20, 10 only. count never exceeds 2. 99 is absent after the return to FILL.
